// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated 32-bit data memory slave with sub-word access and bus errors
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_data,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  output logic        mem_ready,
  output logic [31:0] mem_load_data,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             addr_q, data_q, load_data_q;
  logic [1:0]              size_q;
  logic                    signed_q, store_q, bus_error_q;
  logic [31:0]             mem_q [2**ADDR_WIDTH];
  logic                    req, fire, err, in_range, misaligned;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [3:0]              be;
  logic [31:0]             wdata, sh, ext;

  assign req           = mem_load | mem_store;
  assign mem_load_data = load_data_q;
  assign bus_error     = bus_error_q;
  // BASE_ADDR is aligned to the array size, so range check and index use the upper/middle address bits directly
  assign in_range   = addr_q[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign misaligned = (size_q == 2'b11) | (size_q == 2'b01 & addr_q[0]) | (size_q == 2'b10 & |addr_q[1:0]);
  assign err        = !in_range | misaligned;
  assign idx        = addr_q[ADDR_WIDTH+1:2];
  assign be    = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] : size_q == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
  assign wdata = size_q == 2'b00 ? {4{data_q[7:0]}} : size_q == 2'b01 ? {2{data_q[15:0]}} : data_q;
  assign sh    = mem_q[idx] >> {addr_q[1:0], 3'b000};
  assign ext   = size_q == 2'b00 ? {{24{signed_q & sh[7]}}, sh[7:0]} :
                 size_q == 2'b01 ? {{16{signed_q & sh[15]}}, sh[15:0]} : sh;

  // next-state, wait counter and ready; a dropped request during ACCESS aborts before any array access
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_ready = 1'b0;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        mem_ready = !req;
        if (req) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!req) state_d = IDLE;
        else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          fire    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control state, request capture and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      store_q     <= 1'b0;
      load_data_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_error_q <= fire & err;
      if (state_q == IDLE && req) begin
        addr_q   <= mem_addr;
        data_q   <= mem_store_data;
        size_q   <= mem_size;
        signed_q <= mem_signed;
        store_q  <= mem_store;
      end
      if (fire) load_data_q <= (!store_q && !err) ? ext : '0;
    end
  end

  // byte-enabled array write; contents survive reset, and reset forces IDLE so no write can fire
  always_ff @(posedge clk) begin
    if (fire && store_q && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of latency, sub-word access, errors, abort and reset
module tb_data_mem_responder;
  logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic [31:0] mem_addr = '0, mem_store_data = '0;
  logic        mem_load = 1'b0, mem_store = 1'b0, mem_signed = 1'b0;
  logic [1:0]  mem_size = 2'b10;
  logic        r1, r3, e1, e3, rdy, de;
  logic [31:0] q1, q3, dq;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign rdy = sel ? r3 : r1;
  assign dq  = sel ? q3 : q1;
  assign de  = sel ? e3 : e1;

  data_mem_responder #(.WAIT_STATES(1)) u1 (.clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .mem_load(mem_load), .mem_store(mem_store), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_ready(r1), .mem_load_data(q1), .bus_error(e1));
  data_mem_responder #(.WAIT_STATES(3)) u3 (.clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .mem_load(mem_load), .mem_store(mem_store), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_ready(r3), .mem_load_data(q3), .bus_error(e3));

  // one transfer starting on a falling edge; counts ready-low cycles and captures DONE outputs
  task automatic xfer(input logic l, input logic s, input logic [31:0] a, input logic [31:0] d, input logic [1:0] z,
                      input logic g, output int lows, output logic [31:0] q, output logic e);
    mem_addr = a; mem_store_data = d; mem_size = z; mem_signed = g; mem_load = l; mem_store = s;
    lows = 0;
    #1;
    while (!rdy && lows < 40) begin
      lows++;
      @(negedge clk);
      #1;
    end
    q = dq; e = de;
    mem_load = 1'b0; mem_store = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", rdy); end
    checks++; if (dq !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 00000000", dq); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", de); end
    mem_load = 1'b1; #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_ready_req got %b exp 0", rdy); end
    mem_load = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    int n; logic [31:0] q; logic e;
    xfer(0, 1, 32'h0001_0010, 32'hDEADBEEF, 2'b10, 0, n, q, e);
    checks++; if (n !== 3) begin errors++; $display("FAIL st_word_lat got %0d exp 3", n); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL st_word_err got %b exp 0", e); end
    xfer(1, 0, 32'h0001_0010, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (n !== 3) begin errors++; $display("FAIL ld_word_lat got %0d exp 3", n); end
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word got %h exp deadbeef", q); end
    #1;
    checks++; if (dq !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_hold got %h exp deadbeef", dq); end
  endtask

  task automatic test_byte();
    int n; logic [31:0] q; logic e;
    xfer(0, 1, 32'h0001_0010, 32'h11223344, 2'b10, 0, n, q, e);
    xfer(0, 1, 32'h0001_0013, 32'hABCDEF80, 2'b00, 0, n, q, e);
    xfer(1, 0, 32'h0001_0010, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'h80223344) begin errors++; $display("FAIL st_byte_word got %h exp 80223344", q); end
    xfer(1, 0, 32'h0001_0013, 32'h0, 2'b00, 1, n, q, e);
    checks++; if (q !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s got %h exp ffffff80", q); end
    xfer(1, 0, 32'h0001_0013, 32'h0, 2'b00, 0, n, q, e);
    checks++; if (q !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u got %h exp 00000080", q); end
  endtask

  task automatic test_half();
    int n; logic [31:0] q; logic e;
    xfer(1, 0, 32'h0001_0012, 32'h0, 2'b01, 1, n, q, e);
    checks++; if (q !== 32'hFFFF8022) begin errors++; $display("FAIL ld_half_s got %h exp ffff8022", q); end
    xfer(1, 0, 32'h0001_0012, 32'h0, 2'b01, 0, n, q, e);
    checks++; if (q !== 32'h00008022) begin errors++; $display("FAIL ld_half_u got %h exp 00008022", q); end
    xfer(0, 1, 32'h0001_0011, 32'h0000FFFF, 2'b01, 0, n, q, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL st_half_mis_err got %b exp 1", e); end
    checks++; if (n !== 3) begin errors++; $display("FAIL st_half_mis_lat got %0d exp 3", n); end
    xfer(1, 0, 32'h0001_0010, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'h80223344) begin errors++; $display("FAIL st_half_mis_word got %h exp 80223344", q); end
    xfer(0, 1, 32'h0001_0012, 32'h1234BEEF, 2'b01, 0, n, q, e);
    xfer(1, 0, 32'h0001_0010, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'hBEEF3344) begin errors++; $display("FAIL st_half_word got %h exp beef3344", q); end
    xfer(1, 0, 32'h0001_0010, 32'h0, 2'b01, 0, n, q, e);
    checks++; if (q !== 32'h00003344) begin errors++; $display("FAIL ld_half_lo got %h exp 00003344", q); end
    xfer(1, 0, 32'h0001_0011, 32'h0, 2'b00, 0, n, q, e);
    checks++; if (q !== 32'h00000033) begin errors++; $display("FAIL ld_byte1_u got %h exp 00000033", q); end
    xfer(1, 0, 32'h0001_0012, 32'h0, 2'b00, 1, n, q, e);
    checks++; if (q !== 32'hFFFFFFEF) begin errors++; $display("FAIL ld_byte2_s got %h exp ffffffef", q); end
  endtask

  task automatic test_error();
    int n; logic [31:0] q; logic e;
    xfer(1, 0, 32'h0000_0000, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL oor_data got %h exp 00000000", q); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", e); end
    checks++; if (n !== 3) begin errors++; $display("FAIL oor_lat got %0d exp 3", n); end
    #1;
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL oor_pulse got %b exp 0", de); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL oor_idle_ready got %b exp 1", rdy); end
    xfer(0, 1, 32'h0001_0FFC, 32'h12345678, 2'b10, 0, n, q, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL top_word_err got %b exp 0", e); end
    xfer(1, 0, 32'h0001_0FFC, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'h12345678) begin errors++; $display("FAIL top_word got %h exp 12345678", q); end
    xfer(1, 0, 32'h0001_1000, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (e !== 1'b1 || q !== 32'h0) begin errors++; $display("FAIL past_end got err=%b data=%h exp err=1 data=0", e, q); end
    xfer(1, 0, 32'h0001_0010, 32'h0, 2'b11, 0, n, q, e);
    checks++; if (e !== 1'b1 || q !== 32'h0) begin errors++; $display("FAIL size3 got err=%b data=%h exp err=1 data=0", e, q); end
    xfer(1, 0, 32'h0001_0012, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (e !== 1'b1 || q !== 32'h0) begin errors++; $display("FAIL word_mis got err=%b data=%h exp err=1 data=0", e, q); end
  endtask

  task automatic test_back_to_back();
    int n; logic [31:0] q; logic e;
    logic [7:0] pat = 8'b1000_1000;
    mem_addr = 32'h0001_0014; mem_store_data = 32'h55AA55AA; mem_size = 2'b10; mem_store = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (rdy !== pat[i]) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, rdy, pat[i]); end
      @(negedge clk);
    end
    mem_store = 1'b0;
    @(negedge clk);
    xfer(1, 0, 32'h0001_0014, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'h55AA55AA) begin errors++; $display("FAIL b2b_data got %h exp 55aa55aa", q); end
  endtask

  task automatic test_reset_abort();
    int n; logic [31:0] q; logic e;
    xfer(0, 1, 32'h0001_0018, 32'h11111111, 2'b10, 0, n, q, e);
    xfer(1, 0, 32'h0001_0018, 32'h0, 2'b10, 0, n, q, e);
    mem_addr = 32'h0001_0018; mem_store_data = 32'h22222222; mem_store = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; mem_store = 1'b0; #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rabort_ready got %b exp 1", rdy); end
    checks++; if (dq !== 32'h0) begin errors++; $display("FAIL rabort_data got %h exp 00000000", dq); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rabort_idle got %b exp 1", rdy); end
    @(negedge clk);
    xfer(1, 0, 32'h0001_0018, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'h11111111) begin errors++; $display("FAIL rabort_word got %h exp 11111111", q); end
  endtask

  task automatic test_abort();
    int n; logic [31:0] q; logic e;
    sel = 1'b1;
    xfer(0, 1, 32'h0001_0020, 32'hCAFEF00D, 2'b10, 0, n, q, e);
    checks++; if (n !== 5) begin errors++; $display("FAIL ws3_lat got %0d exp 5", n); end
    mem_addr = 32'h0001_0020; mem_store_data = 32'h0BADBEEF; mem_store = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_store = 1'b0; #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL abort_access got %b exp 0", rdy); end
    @(negedge clk); #1;
    checks++; if (rdy !== 1'b1 || de !== 1'b0) begin errors++; $display("FAIL abort_idle got rdy=%b err=%b exp rdy=1 err=0", rdy, de); end
    @(negedge clk);
    xfer(1, 0, 32'h0001_0020, 32'h0, 2'b10, 0, n, q, e);
    checks++; if (q !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_word got %h exp cafef00d", q); end
    checks++; if (n !== 5) begin errors++; $display("FAIL ws3_ld_lat got %0d exp 5", n); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_error();
    test_back_to_back();
    test_reset_abort();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0001_0000, SHALL set the byte address of word 0; it is aligned to 4*2^ADDR_WIDTH.
REQ-003 Parameter WAIT_STATES, default 1, range 0..15, SHALL set the extra ACCESS cycles per transfer.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mem_addr  input  32  byte address, held stable by the initiator while a request is pending.
REQ-007 mem_store_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 mem_load  input  1  load request.
REQ-009 mem_store  input  1  store request; never asserted together with mem_load.
REQ-010 mem_size  input  2  00 byte, 01 half, 10 word; 11 SHALL be treated as an error access.
REQ-011 mem_signed  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-012 mem_ready  output  1  high when no transfer is pending or the current transfer completes this cycle.
REQ-013 mem_load_data  output  32  extended load result, valid while mem_ready=1 in DONE.
REQ-014 bus_error  output  1  one-cycle pulse in DONE for an error access.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE; a 4-bit wait counter.
REQ-016 IDLE: mem_ready SHALL equal !(mem_load||mem_store); on a request, latch addr/data/size/signed/direction, load counter with WAIT_STATES, go to ACCESS.
REQ-017 ACCESS: mem_ready=0; counter !=0 decrements; counter ==0 performs the array operation and goes to DONE.
REQ-018 ACCESS with mem_load and mem_store both low SHALL abort: no write, return to IDLE, no DONE.
REQ-019 DONE: mem_ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 Request-to-ready latency SHALL be WAIT_STATES+2 cycles with mem_ready low; WAIT_STATES=0 gives 2 low cycles, ready high in the 3rd.
REQ-021 A request still asserted in the cycle after DONE SHALL start a new transfer; re-issued stores and loads are idempotent.
REQ-022 Error access: size 11, or address outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH), or misaligned (half addr[0]=1, word addr[1:0]!=0). It SHALL NOT write, SHALL return load data 0, and SHALL pulse bus_error in DONE.
REQ-023 Word index SHALL be (addr-BASE_ADDR)[ADDR_WIDTH+1:2].
REQ-024 Store byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Data replicates across lanes; only enabled bytes change.
REQ-025 Load: word>>(8*addr[1:0]), truncated to size, then extended per mem_signed; word loads pass through unchanged.
REQ-026 mem_load_data SHALL be registered at the ACCESS->DONE edge and hold until the next DONE.

Reset
REQ-027 While rst_n=0: state IDLE, counter 0, mem_load_data 0, bus_error 0; mem_ready follows REQ-016.
REQ-028 Reset asserted in ACCESS SHALL abort the transfer with no array write; array contents are not reset.
REQ-029 Deassertion is synchronized externally; the first edge after release SHALL see IDLE.

Verification
REQ-030 WAIT_STATES=1: store word 32'hDEADBEEF at 0x0001_0010, then load word at the same address -> mem_ready low 3 cycles each, load returns 32'hDEADBEEF.
REQ-031 Store byte 8'h80 at 0x0001_0013 over 32'h11223344 -> word becomes 32'h80223344; signed byte load returns 32'hFFFFFF80, unsigned returns 32'h00000080.
REQ-032 Load half signed at 0x0001_0012 of word 32'h80223344 -> 32'hFFFF8022; store half at 0x0001_0011 -> bus_error pulse, word unchanged.
REQ-033 Load at 0x0000_0000 (out of range) -> mem_load_data 0, bus_error 1 for one cycle in DONE, mem_ready high in that same cycle.
REQ-034 WAIT_STATES=3: store at 0x0001_0020 with mem_store dropped in the 2nd ACCESS cycle -> IDLE next cycle, no DONE, memory unchanged.
REQ-035 rst_n pulsed low in ACCESS of a store -> IDLE, mem_ready=1 with no request, target word unchanged on a read-back.
